// File: rtl/conv1_layer1_pkg.sv
// Shared constants for the conv1 layer1 accumulation tree: lane geometry,
// Q8.8 format, internal widths and saturation limits.
package conv1_layer1_pkg;

    localparam int unsigned LANES  = 25;
    localparam int unsigned DW     = 16;
    localparam int unsigned FRAC   = 8;
    localparam int unsigned TREE_W = DW + 5;
    localparam int unsigned ACC_W  = TREE_W + 8;

    localparam logic [DW-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DW-1:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/conv1_layer1_add_stage.sv
// One adder-tree level: pairwise sums plus an odd pass-through operand,
// registered under ~halt with an asynchronous active-low clear.
module conv1_layer1_add_stage
    import conv1_layer1_pkg::*;
#(
    parameter int unsigned N_IN = LANES,
    parameter int unsigned W    = TREE_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          halt,
    input  logic [N_IN*W-1:0]             din,
    output logic [((N_IN+1)/2)*W-1:0]     dout
);

    localparam int unsigned N_OUT = (N_IN + 1) / 2;

    logic [N_OUT*W-1:0] sum;

    for (genvar i = 0; i < N_IN / 2; i++) begin : g_pair
        assign sum[i*W +: W] = din[2*i*W +: W] + din[(2*i+1)*W +: W];
    end

    if (N_IN % 2 == 1) begin : g_odd
        assign sum[(N_OUT-1)*W +: W] = din[(N_IN-1)*W +: W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= '0;
        end else if (!halt) begin
            dout <= sum;
        end
    end

endmodule

// File: rtl/conv1_layer1_acc_tree.sv
// Reduces 25 signed Q8.8 products per beat through a 5-stage adder tree,
// accumulates CH_NUM beats plus bias and emits one saturated Q8.8 result.
module conv1_layer1_acc_tree #(
    parameter int unsigned LANES  = conv1_layer1_pkg::LANES,
    parameter int unsigned DW     = conv1_layer1_pkg::DW,
    parameter int unsigned CH_NUM = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                halt,
    input  logic [LANES*DW-1:0] mult_res_w,
    input  logic                mult_res_v_w,
    input  logic [DW-1:0]       bias_w,
    output logic [DW-1:0]       acc_res_w,
    output logic                acc_res_v_w,
    output logic                busy
);

    localparam int unsigned TW = DW + 5;
    localparam int unsigned AW = TW + 8;
    localparam int unsigned N1 = (LANES + 1) / 2;
    localparam int unsigned N2 = (N1 + 1) / 2;
    localparam int unsigned N3 = (N2 + 1) / 2;
    localparam int unsigned N4 = (N3 + 1) / 2;
    localparam int unsigned N5 = (N4 + 1) / 2;

    logic [LANES*TW-1:0]    lanes_ext;
    logic [N1*TW-1:0]       s1;
    logic [N2*TW-1:0]       s2;
    logic [N3*TW-1:0]       s3;
    logic [N4*TW-1:0]       s4;
    logic [N5*TW-1:0]       s5;
    logic [4:0]             vld;
    logic [4:0][DW-1:0]     bias_pipe;
    logic [7:0]             ch_cnt;
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   acc_next;
    logic signed [AW-1:0]   tree_sum;
    logic signed [AW-1:0]   bias_ext;
    logic [DW-1:0]          sat_val;
    logic                   last;
    logic                   res_v;

    for (genvar i = 0; i < LANES; i++) begin : g_ext
        assign lanes_ext[i*TW +: TW] = {{(TW-DW){mult_res_w[i*DW+DW-1]}}, mult_res_w[i*DW +: DW]};
    end

    conv1_layer1_add_stage #(.N_IN(LANES), .W(TW)) u_stage1 (.clk(clk), .rst(rst), .halt(halt), .din(lanes_ext), .dout(s1));
    conv1_layer1_add_stage #(.N_IN(N1),    .W(TW)) u_stage2 (.clk(clk), .rst(rst), .halt(halt), .din(s1),        .dout(s2));
    conv1_layer1_add_stage #(.N_IN(N2),    .W(TW)) u_stage3 (.clk(clk), .rst(rst), .halt(halt), .din(s2),        .dout(s3));
    conv1_layer1_add_stage #(.N_IN(N3),    .W(TW)) u_stage4 (.clk(clk), .rst(rst), .halt(halt), .din(s3),        .dout(s4));
    conv1_layer1_add_stage #(.N_IN(N4),    .W(TW)) u_stage5 (.clk(clk), .rst(rst), .halt(halt), .din(s4),        .dout(s5));

    assign tree_sum = {{(AW-TW){s5[TW-1]}}, s5[TW-1:0]};
    assign bias_ext = {{(AW-DW){bias_pipe[4][DW-1]}}, bias_pipe[4]};
    assign last     = (ch_cnt == 8'(CH_NUM - 1));

    always_comb begin
        acc_next = (ch_cnt == '0) ? tree_sum + bias_ext : acc + tree_sum;
        if (acc_next > $signed({{(AW-DW){1'b0}}, conv1_layer1_pkg::SAT_MAX})) begin
            sat_val = conv1_layer1_pkg::SAT_MAX;
        end else if (acc_next < $signed({{(AW-DW){1'b1}}, conv1_layer1_pkg::SAT_MIN})) begin
            sat_val = conv1_layer1_pkg::SAT_MIN;
        end else begin
            sat_val = acc_next[DW-1:0];
        end
    end

    // Bias rides a pipe alongside its beat, so the channel-0 beat brings its own bias to stage 6.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld       <= '0;
            bias_pipe <= '0;
            ch_cnt    <= '0;
            acc       <= '0;
            acc_res_w <= '0;
            res_v     <= 1'b0;
        end else if (!halt) begin
            vld       <= {vld[3:0], mult_res_v_w};
            bias_pipe <= {bias_pipe[3:0], bias_w};
            res_v     <= 1'b0;
            if (vld[4]) begin
                acc    <= acc_next;
                ch_cnt <= last ? '0 : ch_cnt + 8'd1;
                if (last) begin
                    acc_res_w <= sat_val;
                    res_v     <= 1'b1;
                end
            end
        end
    end

    // Pulse register holds through halt; gating defers rather than drops it.
    assign acc_res_v_w = res_v & ~halt;
    assign busy        = (|vld) | (ch_cnt != '0);

endmodule

// File: tb/tb_conv1_layer1_acc_tree.sv
// Bench for conv1_layer1_acc_tree: directed vector table and corner sequences
// plus randomized traffic against a beat-level arithmetic scoreboard.
module tb_conv1_layer1_acc_tree;

    localparam int unsigned LANES = 25;
    localparam int unsigned DW    = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                halt;
    logic [LANES*DW-1:0] mres;
    logic                mv;
    logic [DW-1:0]       bias;
    logic [DW-1:0]       res3, res1;
    logic                v3, v1, busy3, busy1;

    always #5 clk = ~clk;

    conv1_layer1_acc_tree #(.LANES(LANES), .DW(DW), .CH_NUM(3)) dut3 (
        .clk(clk), .rst(rst), .halt(halt), .mult_res_w(mres), .mult_res_v_w(mv),
        .bias_w(bias), .acc_res_w(res3), .acc_res_v_w(v3), .busy(busy3)
    );

    conv1_layer1_acc_tree #(.LANES(LANES), .DW(DW), .CH_NUM(1)) dut1 (
        .clk(clk), .rst(rst), .halt(halt), .mult_res_w(mres), .mult_res_v_w(mv),
        .bias_w(bias), .acc_res_w(res1), .acc_res_v_w(v1), .busy(busy1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sat16(input int v);
        int r;
        r = (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
        return r & 32'hFFFF;
    endfunction

    // Reference model: each accepted beat is summed arithmetically; pixels
    // complete every 3 beats (CH_NUM=3) or every beat (CH_NUM=1).
    typedef struct { int val; int adv; } exp_t;
    exp_t q3[$];
    exp_t q1[$];
    int   adv   = 0;
    int   m_cnt = 0;
    int   m_acc = 0;

    always @(posedge clk) begin : model
        int s;
        int b;
        exp_t e;
        if (rst !== 1'b1) begin
            m_cnt = 0;
            m_acc = 0;
            q3.delete();
            q1.delete();
        end else if (!halt) begin
            adv++;
            if (mv) begin
                s = 0;
                for (int i = 0; i < LANES; i++) s += int'($signed(mres[i*DW +: DW]));
                b = int'($signed(bias));
                e.adv = adv;
                e.val = sat16(s + b);
                q1.push_back(e);
                if (m_cnt == 0) m_acc = s + b;
                else            m_acc += s;
                m_cnt++;
                if (m_cnt == 3) begin
                    e.val = sat16(m_acc);
                    q3.push_back(e);
                    m_cnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (v3) begin
                check("sb3_pulse_expected", int'(q3.size() != 0), 1);
                if (q3.size() != 0) begin
                    check("sb3_value", int'(res3), q3[0].val);
                    check("sb3_latency", adv, q3[0].adv + 5);
                    q3.delete(0);
                end
            end else if (q3.size() != 0 && !halt && adv >= q3[0].adv + 5) begin
                check("sb3_pulse_present", int'(v3), 1);
                q3.delete(0);
            end
            if (v1) begin
                check("sb1_pulse_expected", int'(q1.size() != 0), 1);
                if (q1.size() != 0) begin
                    check("sb1_value", int'(res1), q1[0].val);
                    check("sb1_latency", adv, q1[0].adv + 5);
                    q1.delete(0);
                end
            end else if (q1.size() != 0 && !halt && adv >= q1[0].adv + 5) begin
                check("sb1_pulse_present", int'(v1), 1);
                q1.delete(0);
            end
        end
    end

    // Drives n beats (held while halted) starting at edge 0, halt over edges
    // [hs, hs+hl), and records the edge index after which each dut3 pulse shows.
    task automatic run_pixel(input logic [15:0] a, input logic [15:0] b, input logic [15:0] bv,
                             input int n, input int hs, input int hl,
                             output int np, output int lat0, output int lat1,
                             output logic [15:0] val0, output logic [15:0] val1);
        int left;
        logic [15:0] prev;
        logic prev_busy;
        logic halted_prev;
        left = n; np = 0; lat0 = -1; lat1 = -1; val0 = '0; val1 = '0;
        prev = res3; prev_busy = busy3; halted_prev = 1'b0;
        for (int k = 0; k < 24; k++) begin
            halt = (k >= hs && k < hs + hl);
            mv   = (left > 0);
            bias = bv;
            for (int i = 0; i < LANES; i++) mres[i*DW +: DW] = (i % 2 == 0) ? a : b;
            @(negedge clk);
            if (k == 1 && n > 0) check("busy_in_flight", int'(busy3), 1);
            if (halt) check("halt_forces_valid_low", int'(v3), 0);
            if (halted_prev) begin
                check("halt_result_frozen", int'(res3), int'(prev));
                check("halt_busy_frozen", int'(busy3), int'(prev_busy));
            end
            if (v3) begin
                if (np == 0) begin lat0 = k - 1; val0 = res3; end
                else if (np == 1) begin lat1 = k - 1; val1 = res3; end
                np++;
            end
            prev = res3; prev_busy = busy3; halted_prev = halt;
            @(posedge clk);
            if (mv && !halt) left--;
            #1;
        end
        halt = 1'b0;
        mv   = 1'b0;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] bias;
        logic [15:0] exp3;
        logic [15:0] exp1;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int np, lat0, lat1;
        logic [15:0] val0, val1;

        tbl[0] = '{16'h0100, 16'h0100, 16'h0000, 16'h4B00, 16'h1900};
        tbl[1] = '{16'h0100, 16'hFF00, 16'h0080, 16'h0380, 16'h0180};
        tbl[2] = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF};
        tbl[3] = '{16'h8000, 16'h8000, 16'h0000, 16'h8000, 16'h8000};
        tbl[4] = '{16'h0010, 16'h0010, 16'hFFF0, 16'h04A0, 16'h0180};
        tbl[5] = '{16'h0001, 16'h0000, 16'h0000, 16'h0027, 16'h000D};

        rst = 1'b0; halt = 1'b0; mv = 1'b0; mres = '0; bias = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_res3", int'(res3), 0);
        check("reset_v3", int'(v3), 0);
        check("reset_busy3", int'(busy3), 0);
        check("reset_res1", int'(res1), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int t = 0; t < 6; t++) begin
            run_pixel(tbl[t].a, tbl[t].b, tbl[t].bias, 3, 0, 0, np, lat0, lat1, val0, val1);
            check($sformatf("vec%0d_pulses", t), np, 1);
            check($sformatf("vec%0d_latency", t), lat0, 7);
            check($sformatf("vec%0d_res3", t), int'(val0), int'(tbl[t].exp3));
            check($sformatf("vec%0d_res1", t), int'(res1), int'(tbl[t].exp1));
            check($sformatf("vec%0d_busy_idle", t), int'(busy3), 0);
        end

        run_pixel(16'h0100, 16'h0100, 16'h0000, 3, 2, 3, np, lat0, lat1, val0, val1);
        check("halt_pulses", np, 1);
        check("halt_latency", lat0, 10);
        check("halt_res3", int'(val0), 16'h4B00);

        run_pixel(16'h0200, 16'h0200, 16'h0000, 2, 0, 0, np, lat0, lat1, val0, val1);
        check("partial_no_pulse", np, 0);
        check("partial_busy", int'(busy3), 1);
        rst = 1'b0;
        @(negedge clk);
        check("midreset_res3", int'(res3), 0);
        check("midreset_v3", int'(v3), 0);
        check("midreset_busy3", int'(busy3), 0);
        check("midreset_res1", int'(res1), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        run_pixel(16'h0100, 16'h0100, 16'h0000, 3, 0, 0, np, lat0, lat1, val0, val1);
        check("after_reset_pulses", np, 1);
        check("after_reset_latency", lat0, 7);
        check("after_reset_res3", int'(val0), 16'h4B00);

        run_pixel(16'h0100, 16'h0100, 16'h0000, 6, 0, 0, np, lat0, lat1, val0, val1);
        check("stream_pulses", np, 2);
        check("stream_first_latency", lat0, 7);
        check("stream_spacing", lat1 - lat0, 3);
        check("stream_res3_first", int'(val0), 16'h4B00);
        check("stream_res3_second", int'(val1), 16'h4B00);

        for (int c = 0; c < 600; c++) begin
            halt = ($urandom_range(0, 4) == 0);
            mv   = ($urandom_range(0, 9) < 7);
            bias = 16'($urandom_range(0, 1023)) - 16'd512;
            for (int i = 0; i < LANES; i++) begin
                if ($urandom_range(0, 3) == 0) mres[i*DW +: DW] = 16'($urandom);
                else                           mres[i*DW +: DW] = 16'($urandom_range(0, 2047)) - 16'd1024;
            end
            @(posedge clk); #1;
        end
        halt = 1'b0;
        mv   = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("drain_q3_empty", q3.size(), 0);
        check("drain_q1_empty", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
